id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the RV64 core; sits directly upstream of the ALU and drives its `a`, `b` and `sel` inputs from a registered slot. It selects the operand sources (register, PC, immediate, zero) and resolves EX/MEM and MEM/WB forwarding at capture time. It applies a one-cycle load-use stall and carries destination and store-data sideband to the memory stage. Handshake is valid/ready on both sides, with a flush input from branch resolution.

## Interface
- `DATA_WIDTH`, 64, operand/result width
- `REG_ADDR_W`, 5, register index width
- `clk  in  1  clock; all state on rising edge`
- `rst_n  in  1  asynchronous active-low reset`
- `in_valid  in  1  decoded instruction present`
- `in_ready  out  1  stage accepts instruction this cycle`
- `in_pc  in  DATA_WIDTH  instruction PC`
- `in_rs1_addr, in_rs2_addr  in  REG_ADDR_W  source indices`
- `in_rs1_data, in_rs2_data  in  DATA_WIDTH  register-file read data`
- `in_imm  in  DATA_WIDTH  sign-extended immediate`
- `in_a_sel  in  2  0=rs1, 1=PC, 2=zero, 3=zero`
- `in_b_sel  in  1  0=rs2, 1=imm`
- `in_alu_op  in  5  ALU op code (alu_op_e)`
- `in_rd_addr  in  REG_ADDR_W`; `in_rd_we  in  1`; `in_is_load  in  1`
- `exm_rd_we  in  1`; `exm_rd_addr  in  REG_ADDR_W`; `exm_data  in  DATA_WIDTH`; `exm_is_load  in  1` (instruction currently in EX/MEM)
- `mwb_rd_we  in  1`; `mwb_rd_addr  in  REG_ADDR_W`; `mwb_data  in  DATA_WIDTH` (MEM/WB writeback)
- `flush  in  1  kill held and incoming instruction`
- `out_valid  out  1`; `out_ready  in  1`
- `out_a, out_b  out  DATA_WIDTH  ALU operands`; `out_sel  out  5  ALU op`
- `out_store_data  out  DATA_WIDTH  forwarded rs2`
- `out_pc  out  DATA_WIDTH`; `out_rd_addr  out  REG_ADDR_W`; `out_rd_we  out  1`; `out_is_load  out  1`

## Operation
- One-entry register slot.
- Forwarding per source, evaluated combinationally at capture:
  - Use EX/MEM if `exm_rd_we` and `exm_rd_addr` matches the source index.
  - Otherwise use MEM/WB if `mwb_rd_we` and `mwb_rd_addr` matches.
  - Otherwise use register-file data.
  - EX/MEM has priority over MEM/WB.
  - Index 0 is never forwarded; x0 reads as register-file data.
- Load-use hazard:
  - Condition: `exm_is_load` and `exm_rd_we` and `exm_rd_addr`≠0 matches rs1 (when `in_a_sel`=0) or rs2 (when `in_b_sel`=0 or `in_is_load`=0 store path).
  - Action: force `in_ready`=0.
- Operand mux:
  - `out_a` = fwd_rs1 / `in_pc` / 0 per `in_a_sel`.
  - `out_b` = fwd_rs2 or `in_imm` per `in_b_sel`.
  - `out_store_data` = fwd_rs2 always.
- `in_alu_op` is captured unchanged, including unused codes 15–31 (the ALU returns 0 for those).

## Timing
- Reset: `out_valid`=0 and every data/sideband output 0 (`out_sel`=ADD).
- `in_ready` = (!`out_valid` | `out_ready`) & !hazard & !`flush`.
- Capture: when `in_valid` & `in_ready` on a rising edge, the slot loads and `out_valid`=1 next cycle. Latency is one cycle.
- Hold: while `out_valid` & !`out_ready`, all outputs are stable.
- Drain: when `out_valid` & `out_ready` & no capture, `out_valid` goes to 0 next cycle. Drain and capture can occur in the same cycle (full throughput, one instruction per cycle).
- `flush`: `out_valid`=0 next cycle regardless of other inputs; overrides simultaneous capture and hold. Data registers may retain stale values.
- Stall-only cycles do not change the slot.
- Reset asserted mid-operation: outputs clear immediately (asynchronous), and `in_ready` stays 0 while `rst_n`=0.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` (ADD=0, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, ADDW, SUBW, SLLW, SRLW, SRAW=14).
  - `a_sel_e` and `b_sel_e` operand-select enums.
  - `DATA_WIDTH` and `REG_ADDR_W` constants.
- Sub-module `fwd_mux`: single-source forwarding selector, instantiated twice (rs1, rs2).

## Test plan
- Reset, then one ADD: rs1=5, rs2=7, no matches → next cycle `out_valid`=1, `out_a`=5, `out_b`=7, `out_sel`=0.
- Forwarding priority: rs1=x3, EX/MEM writes x3=0xAA, MEM/WB writes x3=0xBB → `out_a`=0xAA. With only MEM/WB matching → 0xBB. With rs1=x0 and EX/MEM writing x0 → register data.
- Load-use: EX/MEM is a load to x4, incoming rs2=x4 with `in_b_sel`=0 → `in_ready`=0 that cycle. Next cycle, after clearing `exm_is_load` and forwarding via MEM/WB=0x1234 → `out_b`=0x1234.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → outputs frozen and `in_ready`=0. Raise `out_ready` → back-to-back transfers at one per cycle, no loss or duplication.
- Flush while holding with a capture pending → `out_valid`=0 next cycle and incoming instruction dropped.
- Reset asserted mid-stream → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU / decode-to-execute types: op codes, operand selects and the ID/EX slot payload.
package alu_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_ADDW = 5'd10,
        ALU_SUBW = 5'd11,
        ALU_SLLW = 5'd12,
        ALU_SRLW = 5'd13,
        ALU_SRAW = 5'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        A_RS1      = 2'd0,
        A_PC       = 2'd1,
        A_ZERO     = 2'd2,
        A_ZERO_ALT = 2'd3
    } a_sel_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] store_data;
        logic [DATA_WIDTH-1:0] pc;
        logic [4:0]            sel;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  rd_we;
        logic                  is_load;
    } id_ex_slot_t;

    // A writer "hits" a source only for a live write to a non-zero index.
    function automatic logic addr_hit(input logic we,
                                      input logic [REG_ADDR_W-1:0] waddr,
                                      input logic [REG_ADDR_W-1:0] raddr);
        return we && (waddr == raddr) && (raddr != '0);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side handshake, bypass sources, flush and ALU-side handshake.
interface id_ex_stage_if;
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [DATA_WIDTH-1:0] in_rs1_data;
    logic [DATA_WIDTH-1:0] in_rs2_data;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [1:0]            in_a_sel;
    logic                  in_b_sel;
    logic [4:0]            in_alu_op;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_rd_we;
    logic                  in_is_load;

    logic                  exm_rd_we;
    logic [REG_ADDR_W-1:0] exm_rd_addr;
    logic [DATA_WIDTH-1:0] exm_data;
    logic                  exm_is_load;
    logic                  mwb_rd_we;
    logic [REG_ADDR_W-1:0] mwb_rd_addr;
    logic [DATA_WIDTH-1:0] mwb_data;

    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [4:0]            out_sel;
    logic [DATA_WIDTH-1:0] out_store_data;
    logic [DATA_WIDTH-1:0] out_pc;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_rd_we;
    logic                  out_is_load;

    modport master (
        output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_a_sel, in_b_sel, in_alu_op, in_rd_addr, in_rd_we, in_is_load,
               exm_rd_we, exm_rd_addr, exm_data, exm_is_load,
               mwb_rd_we, mwb_rd_addr, mwb_data, flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sel, out_store_data,
               out_pc, out_rd_addr, out_rd_we, out_is_load
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
               in_imm, in_a_sel, in_b_sel, in_alu_op, in_rd_addr, in_rd_we, in_is_load,
               exm_rd_we, exm_rd_addr, exm_data, exm_is_load,
               mwb_rd_we, mwb_rd_addr, mwb_data, flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_sel, out_store_data,
               out_pc, out_rd_addr, out_rd_we, out_is_load
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-source bypass selector: EX/MEM beats MEM/WB beats register file; x0 never bypassed.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_W
) (
    input  logic [AW-1:0] src_addr,
    input  logic [DW-1:0] rf_data,
    input  logic          exm_we,
    input  logic [AW-1:0] exm_addr,
    input  logic [DW-1:0] exm_data,
    input  logic          mwb_we,
    input  logic [AW-1:0] mwb_addr,
    input  logic [DW-1:0] mwb_data,
    output logic [DW-1:0] data
);

    logic src_nz;
    logic exm_hit;
    logic mwb_hit;

    assign src_nz  = (src_addr != '0);
    assign exm_hit = src_nz && exm_we && (exm_addr == src_addr);
    assign mwb_hit = src_nz && mwb_we && (mwb_addr == src_addr);

    always_comb begin
        data = rf_data;
        if (exm_hit)      data = exm_data;
        else if (mwb_hit) data = mwb_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select + bypass at capture, load-use stall, flush, one-entry slot.
module id_ex_stage
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic [1:0][REG_ADDR_W-1:0] src_addr;
    logic [1:0][DATA_WIDTH-1:0] rf_data;
    logic [1:0][DATA_WIDTH-1:0] fwd_data;

    assign src_addr = {bus.in_rs2_addr, bus.in_rs1_addr};
    assign rf_data  = {bus.in_rs2_data, bus.in_rs1_data};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        fwd_mux #(.DW(DATA_WIDTH), .AW(REG_ADDR_W)) u_fwd (
            .src_addr (src_addr[i]),
            .rf_data  (rf_data[i]),
            .exm_we   (bus.exm_rd_we),
            .exm_addr (bus.exm_rd_addr),
            .exm_data (bus.exm_data),
            .mwb_we   (bus.mwb_rd_we),
            .mwb_addr (bus.mwb_rd_addr),
            .mwb_data (bus.mwb_data),
            .data     (fwd_data[i])
        );
    end

    // Load result is not available until MEM; rs2 counts as used for stores (non-loads).
    logic rs1_used;
    logic rs2_used;
    logic hazard;

    assign rs1_used = (bus.in_a_sel == A_RS1);
    assign rs2_used = (bus.in_b_sel == B_RS2) || !bus.in_is_load;
    assign hazard   = bus.exm_is_load &&
                      ((rs1_used && addr_hit(bus.exm_rd_we, bus.exm_rd_addr, bus.in_rs1_addr)) ||
                       (rs2_used && addr_hit(bus.exm_rd_we, bus.exm_rd_addr, bus.in_rs2_addr)));

    logic        out_valid;
    logic        capture;
    id_ex_slot_t slot;
    id_ex_slot_t nxt;

    assign bus.in_ready = rst_n && (!out_valid || bus.out_ready) && !hazard && !bus.flush;
    assign capture      = bus.in_valid && bus.in_ready;

    always_comb begin
        nxt = '0;
        case (a_sel_e'(bus.in_a_sel))
            A_RS1:   nxt.a = fwd_data[0];
            A_PC:    nxt.a = bus.in_pc;
            default: nxt.a = '0;
        endcase
        nxt.b          = (bus.in_b_sel == B_IMM) ? bus.in_imm : fwd_data[1];
        nxt.store_data = fwd_data[1];
        nxt.pc         = bus.in_pc;
        nxt.sel        = bus.in_alu_op;
        nxt.rd_addr    = bus.in_rd_addr;
        nxt.rd_we      = bus.in_rd_we;
        nxt.is_load    = bus.in_is_load;
    end

    // Flush wins over everything; data is only written on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            slot      <= '0;
        end else begin
            if (bus.flush)         out_valid <= 1'b0;
            else if (capture)      out_valid <= 1'b1;
            else if (bus.out_ready) out_valid <= 1'b0;
            if (capture) slot <= nxt;
        end
    end

    assign bus.out_valid      = out_valid;
    assign bus.out_a          = slot.a;
    assign bus.out_b          = slot.b;
    assign bus.out_sel        = slot.sel;
    assign bus.out_store_data = slot.store_data;
    assign bus.out_pc         = slot.pc;
    assign bus.out_rd_addr    = slot.rd_addr;
    assign bus.out_rd_we      = slot.rd_we;
    assign bus.out_is_load    = slot.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs. a rule-level model.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a, b, sd, pc;
        logic [4:0]  sel, rd;
        logic        we, ld;
    } exp_t;

    logic m_vld;
    exp_t m_slot;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_src(input logic [4:0] idx, input logic [63:0] rf);
        if (idx == 0) return rf;
        if (bus.exm_rd_we && bus.exm_rd_addr == idx) return bus.exm_data;
        if (bus.mwb_rd_we && bus.mwb_rd_addr == idx) return bus.mwb_data;
        return rf;
    endfunction

    function automatic logic m_stall();
        logic live;
        live = bus.exm_is_load && bus.exm_rd_we && bus.exm_rd_addr != 0;
        if (!live) return 1'b0;
        if (bus.in_a_sel == 0 && bus.exm_rd_addr == bus.in_rs1_addr) return 1'b1;
        if ((bus.in_b_sel == 0 || !bus.in_is_load) && bus.exm_rd_addr == bus.in_rs2_addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_vld"}, bus.out_valid, m_vld);
        if (m_vld) begin
            chk({tag, "_a"},   bus.out_a, m_slot.a);
            chk({tag, "_b"},   bus.out_b, m_slot.b);
            chk({tag, "_sd"},  bus.out_store_data, m_slot.sd);
            chk({tag, "_pc"},  bus.out_pc, m_slot.pc);
            chk({tag, "_sel"}, bus.out_sel, m_slot.sel);
            chk({tag, "_rd"},  bus.out_rd_addr, m_slot.rd);
            chk({tag, "_we"},  bus.out_rd_we, m_slot.we);
            chk({tag, "_ld"},  bus.out_is_load, m_slot.ld);
        end
    endtask

    // Called at a negedge with inputs driven; returns at the next negedge.
    task automatic step(input string tag);
        logic rdy, cap, nvld;
        exp_t nx;
        #1;
        rdy = (!m_vld || bus.out_ready) && !m_stall() && !bus.flush;
        chk({tag, "_rdy"}, bus.in_ready, rdy);
        cap = bus.in_valid && rdy;
        nx  = m_slot;
        if (cap) begin
            nx.a   = (bus.in_a_sel == 0) ? m_src(bus.in_rs1_addr, bus.in_rs1_data) :
                     (bus.in_a_sel == 1) ? bus.in_pc : 64'd0;
            nx.sd  = m_src(bus.in_rs2_addr, bus.in_rs2_data);
            nx.b   = bus.in_b_sel ? bus.in_imm : nx.sd;
            nx.pc  = bus.in_pc;
            nx.sel = bus.in_alu_op;
            nx.rd  = bus.in_rd_addr;
            nx.we  = bus.in_rd_we;
            nx.ld  = bus.in_is_load;
        end
        nvld = !bus.flush && (cap || (m_vld && !bus.out_ready));
        @(posedge clk);
        #1;
        m_vld  = nvld;
        m_slot = nx;
        check_outs(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0; bus.in_a_sel = 0;
        bus.in_b_sel = 0; bus.in_alu_op = 0; bus.in_rd_addr = 0; bus.in_rd_we = 0;
        bus.in_is_load = 0; bus.exm_rd_we = 0; bus.exm_rd_addr = 0; bus.exm_data = 0;
        bus.exm_is_load = 0; bus.mwb_rd_we = 0; bus.mwb_rd_addr = 0; bus.mwb_data = 0;
        bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [63:0] d1,
                         input logic [4:0] rs2, input logic [63:0] d2,
                         input logic [1:0] asel, input logic bsel, input logic [4:0] op);
        bus.in_valid = 1; bus.in_rs1_addr = rs1; bus.in_rs1_data = d1;
        bus.in_rs2_addr = rs2; bus.in_rs2_data = d2; bus.in_a_sel = asel;
        bus.in_b_sel = bsel; bus.in_alu_op = op;
        bus.in_pc = {$urandom, $urandom}; bus.in_imm = {$urandom, $urandom};
        bus.in_rd_addr = 5'($urandom); bus.in_rd_we = 1'($urandom); bus.in_is_load = 0;
    endtask

    task automatic rand_in(input bit allow_haz);
        bus.in_valid    = ($urandom_range(0, 3) != 0);
        bus.in_pc       = {$urandom, $urandom};
        bus.in_rs1_addr = 5'($urandom_range(0, 7));
        bus.in_rs2_addr = 5'($urandom_range(0, 7));
        bus.in_rs1_data = {$urandom, $urandom};
        bus.in_rs2_data = {$urandom, $urandom};
        bus.in_imm      = {$urandom, $urandom};
        bus.in_a_sel    = 2'($urandom);
        bus.in_b_sel    = 1'($urandom);
        bus.in_alu_op   = 5'($urandom);
        bus.in_rd_addr  = 5'($urandom);
        bus.in_rd_we    = 1'($urandom);
        bus.in_is_load  = 1'($urandom);
        bus.exm_rd_we   = 1'($urandom);
        bus.exm_rd_addr = 5'($urandom_range(0, 7));
        bus.exm_data    = {$urandom, $urandom};
        bus.exm_is_load = allow_haz && ($urandom_range(0, 2) == 0);
        bus.mwb_rd_we   = 1'($urandom);
        bus.mwb_rd_addr = 5'($urandom_range(0, 7));
        bus.mwb_data    = {$urandom, $urandom};
        bus.flush       = allow_haz && ($urandom_range(0, 15) == 0);
        bus.out_ready   = ($urandom_range(0, 3) != 0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_vld"}, bus.out_valid, 0);
        chk({tag, "_rdy"}, bus.in_ready, 0);
        chk({tag, "_a"},   bus.out_a, 0);
        chk({tag, "_b"},   bus.out_b, 0);
        chk({tag, "_sel"}, bus.out_sel, 0);
        chk({tag, "_sd"},  bus.out_store_data, 0);
        chk({tag, "_pc"},  bus.out_pc, 0);
        chk({tag, "_rd"},  {bus.out_rd_addr, bus.out_rd_we, bus.out_is_load}, 0);
    endtask

    initial begin
        logic [63:0] snap_a, snap_pc, last_pc;
        idle();
        m_vld = 0; m_slot = '{default: '0};
        rst_n = 1;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        all_zero("reset");
        rst_n = 1;

        // plain ADD
        instr(5'd1, 64'd5, 5'd2, 64'd7, 2'd0, 1'b0, 5'd0);
        step("add");
        chk("add_a", bus.out_a, 64'd5);
        chk("add_b", bus.out_b, 64'd7);
        chk("add_sel", bus.out_sel, 0);

        // bypass priority
        instr(5'd3, 64'h11, 5'd0, 64'h0, 2'd0, 1'b1, 5'd1);
        bus.exm_rd_we = 1; bus.exm_rd_addr = 3; bus.exm_data = 64'hAA;
        bus.mwb_rd_we = 1; bus.mwb_rd_addr = 3; bus.mwb_data = 64'hBB;
        step("fwd_both");
        chk("fwd_exm", bus.out_a, 64'hAA);
        bus.exm_rd_we = 0;
        step("fwd_mwb");
        chk("fwd_mwb", bus.out_a, 64'hBB);
        instr(5'd0, 64'h99, 5'd0, 64'h0, 2'd0, 1'b1, 5'd2);
        bus.exm_rd_we = 1; bus.exm_rd_addr = 0; bus.mwb_rd_addr = 0;
        step("fwd_x0");
        chk("fwd_x0", bus.out_a, 64'h99);
        idle();
        step("drain");

        // load-use stall then MEM/WB bypass
        instr(5'd1, 64'h1, 5'd4, 64'h77, 2'd0, 1'b0, 5'd0);
        bus.exm_is_load = 1; bus.exm_rd_we = 1; bus.exm_rd_addr = 4;
        #1 chk("lu_stall", bus.in_ready, 0);
        step("lu");
        bus.exm_is_load = 0; bus.exm_rd_we = 0;
        bus.mwb_rd_we = 1; bus.mwb_rd_addr = 4; bus.mwb_data = 64'h1234;
        step("lu_fwd");
        chk("lu_b", bus.out_b, 64'h1234);
        idle();

        // backpressure for 3 cycles, then back-to-back stream
        instr(5'd5, 64'h50, 5'd6, 64'h60, 2'd1, 1'b1, 5'd3);
        step("bp_cap");
        snap_a = bus.out_a; snap_pc = bus.out_pc;
        bus.out_ready = 0;
        instr(5'd7, 64'h70, 5'd1, 64'h10, 2'd0, 1'b0, 5'd4);
        repeat (3) begin
            step("bp_hold");
            chk("bp_a", bus.out_a, snap_a);
            chk("bp_pc", bus.out_pc, snap_pc);
        end
        bus.out_ready = 1;
        last_pc = bus.in_pc;
        for (int i = 0; i < 6; i++) begin
            step("b2b");
            chk("b2b_vld", bus.out_valid, 1);
            chk("b2b_pc", bus.out_pc, last_pc);
            rand_in(0);
            bus.in_valid = 1; bus.out_ready = 1;
            last_pc = bus.in_pc;
        end

        // flush while holding with a capture pending
        idle();
        step("fl_drain");
        instr(5'd1, 64'h3, 5'd2, 64'h4, 2'd0, 1'b0, 5'd0);
        step("fl_cap");
        bus.out_ready = 0; bus.flush = 1;
        instr(5'd2, 64'h8, 5'd3, 64'h9, 2'd0, 1'b0, 5'd1);
        step("fl");
        chk("fl_vld", bus.out_valid, 0);
        idle();
        step("fl_drop");
        chk("fl_drop", bus.out_valid, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_in(1);
            step("rnd");
        end

        // async reset mid-stream
        instr(5'd1, 64'hDEAD, 5'd2, 64'hBEEF, 2'd0, 1'b0, 5'd9);
        bus.exm_is_load = 0; bus.flush = 0; bus.out_ready = 1;
        step("pre_rst");
        bus.out_ready = 0;
        #2 rst_n = 0;
        #1 all_zero("mid_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
